// File: rtl/serial_add_sub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_add_sub_pkg;

   // Sequencer states: wait for a request, walk the bits, present the result.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Operation select carried on the M input.
   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   // Majority of three inputs: the carry out of a one-bit full adder.
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/serial_add_sub_full_adder.sv
// One-bit combinational full adder used as the serial bit-slice.
module serial_add_sub_full_adder
   import serial_add_sub_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   // Sum and carry of the current bit position.
   always_comb begin
      s    = a ^ b ^ cin;
      cout = maj3(a, b, cin);
   end

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first.
// Subtraction is done as A + ~B + 1, the +1 coming from presetting the carry.
module serial_add_sub
   import serial_add_sub_pkg::*;
#(
   parameter int WIDTH = 4
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             M,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             C,
   output logic             V
);

   localparam int CW = $clog2(WIDTH + 1);
   // Counter value while the MSB is being processed.
   localparam logic [CW-1:0] CNT_MSB = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             c_q, c_d;
   logic             v_q, v_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;

   logic             fa_sum_s;
   logic             fa_cout_s;
   // Carry into the MSB: during the MSB cycle this is the value in the carry flop.
   logic             cin_msb_s;

   serial_add_sub_full_adder u_full_adder (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .cin  (carry_q),
      .s    (fa_sum_s),
      .cout (fa_cout_s)
   );

   assign cin_msb_s = carry_q;

   // Next-state, datapath and output-register update logic.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      s_d     = s_q;
      c_d     = c_q;
      v_d     = v_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               // B is inverted and the carry preset to 1 for subtraction.
               a_d     = A;
               b_d     = B ^ {WIDTH{M == MODE_SUB}};
               carry_d = (M == MODE_SUB);
               cnt_d   = {CW{1'b0}};
               sum_d   = {WIDTH{1'b0}};
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            a_d     = {1'b0, a_q[WIDTH-1:1]};
            b_d     = {1'b0, b_q[WIDTH-1:1]};
            sum_d   = {fa_sum_s, sum_q[WIDTH-1:1]};
            carry_d = fa_cout_s;
            cnt_d   = cnt_q + CNT_ONE;
            if (cnt_q == CNT_MSB) begin
               // Last bit: publish the completed result together with its flags.
               s_d     = {fa_sum_s, sum_q[WIDTH-1:1]};
               c_d     = fa_cout_s;
               v_d     = cin_msb_s ^ fa_cout_s;
               state_d = ST_DONE;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      done_d = (state_d == ST_DONE);
      busy_d = (state_d != ST_IDLE);
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= {WIDTH{1'b0}};
         b_q     <= {WIDTH{1'b0}};
         carry_q <= 1'b0;
         cnt_q   <= {CW{1'b0}};
         sum_q   <= {WIDTH{1'b0}};
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
      end
   end

   // Registered outputs; result flags only move when an operation completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q    <= {WIDTH{1'b0}};
         c_q    <= 1'b0;
         v_q    <= 1'b0;
         done_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         s_q    <= s_d;
         c_q    <= c_d;
         v_q    <= v_d;
         done_q <= done_d;
         busy_q <= busy_d;
      end
   end

   assign S    = s_q;
   assign C    = c_q;
   assign V    = v_q;
   assign done = done_q;
   assign busy = busy_q;

endmodule
